// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit serializer: accepts one byte on data_ready, shifts it out LSB first
// with a start bit and STOP_BITS stop bits, holding busy high for the whole frame.
module uart_tx_serializer #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD      = 115_200,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] data,
   input  logic       data_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_tx_serializer: CLK_FREQ/BAUD must be >= 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            tx_d   = 1'b1;
            // Only IDLE looks at data_ready, so requests during a frame are dropped.
            if (data_ready) begin
               shreg_d = data;
               busy_d  = 1'b1;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = shreg_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shreg_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (stop_q == STOP_LAST) begin
                  stop_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  stop_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: stimulus pushes expected frames, a line monitor
// decodes every frame on tx and checks bit timing, busy length and tx_done.
module tb_uart_tx_serializer;

   localparam int CPB = 16;

   typedef struct {
      logic [7:0] data;
      int         sb;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       dr_a = 1'b0, dr_b = 1'b0;
   logic       busy_a, done_a, tx_a, busy_b, done_b, tx_b;
   logic       sel = 1'b0;
   logic       mon_en = 1'b1;
   logic       m_tx, m_busy, m_done;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   gaps[$];
   bit   in_frame = 1'b0;
   int   idle_cnt = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .data(data_a), .data_ready(dr_a),
      .busy(busy_a), .tx_done(done_a), .tx(tx_a));

   uart_tx_serializer #(.CLK_FREQ(1600), .BAUD(100), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .data(data_b), .data_ready(dr_b),
      .busy(busy_b), .tx_done(done_b), .tx(tx_b));

   assign m_tx   = sel ? tx_b   : tx_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_done = sel ? done_b : done_a;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line monitor: one frame per start bit seen while busy.
   initial begin
      exp_t e;
      int   nbits, bad, blen, dcnt, b;
      logic expb;
      logic [7:0] rx;
      forever begin
         @(negedge clk);
         if (mon_en && resetn && m_tx === 1'b0 && m_busy === 1'b1) begin
            in_frame = 1'b1;
            gaps.push_back(idle_cnt);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got a frame expected none (t=%0t)", $time);
               e.data = 8'h00;
               e.sb   = sel ? 2 : 1;
            end else begin
               e = exp_q.pop_front();
            end
            nbits = 9 + e.sb;
            bad = 0; blen = 0; dcnt = 0; rx = 8'h00;
            for (int k = 0; k < nbits * CPB; k++) begin
               if (k > 0) @(negedge clk);
               b = k / CPB;
               expb = (b == 0) ? 1'b0 : (b <= 8) ? e.data[b-1] : 1'b1;
               if (m_tx !== expb) bad++;
               if (m_busy === 1'b1) blen++;
               if (m_done !== 1'b0) dcnt++;
               if (k % CPB == CPB / 2 && b >= 1 && b <= 8) rx[b-1] = m_tx;
            end
            chk("frame_bits_bad_cycles", bad, 0);
            chk("rx_byte", int'(rx), int'(e.data));
            chk("busy_len", blen, nbits * CPB);
            chk("done_in_frame", dcnt, 0);
            @(negedge clk);
            chk("end_busy", int'(m_busy), 0);
            chk("end_tx", int'(m_tx), 1);
            chk("end_done", int'(m_done), 1);
            idle_cnt = 1;
            in_frame = 1'b0;
         end else begin
            idle_cnt++;
         end
      end
   end

   task automatic wait_sb(input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !in_frame) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("scoreboard_timeout", 0, 1);
   endtask

   task automatic pulse_a(input logic [7:0] d);
      @(negedge clk);
      data_a = d;
      dr_a   = 1'b1;
      exp_q.push_back('{data: d, sb: 1});
      @(negedge clk);
      dr_a = 1'b0;
   endtask

   // Handshake in the style of the upstream sender: wait for idle, raise, drop soon after busy.
   task automatic send_hs(input logic [7:0] d);
      int n = 0;
      while (busy_a !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      @(negedge clk);
      data_a = d;
      dr_a   = 1'b1;
      exp_q.push_back('{data: d, sb: 1});
      n = 0;
      do begin @(negedge clk); n++; end while (busy_a !== 1'b1 && n < 50);
      if (busy_a !== 1'b1) chk("hs_accept_timeout", 0, 1);
      repeat (3) @(negedge clk);
      dr_a = 1'b0;
   endtask

   initial begin
      int bad, rises;
      logic prev;

      // 1: reset state and quiet idle
      repeat (3) @(negedge clk);
      chk("rst_tx", int'(tx_a), 1);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      resetn = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      end
      chk("idle_quiet_bad_cycles", bad, 0);

      // 2: single 0x55 frame
      pulse_a(8'h55);
      wait_sb(400);

      // 3: mid-frame data change and request are ignored
      pulse_a(8'hA5);
      repeat (38) @(negedge clk);
      data_a = 8'hFF;
      dr_a   = 1'b1;
      @(negedge clk);
      dr_a = 1'b0;
      wait_sb(400);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy_a !== 1'b0) bad++;
      end
      chk("no_second_frame", bad, 0);

      // 4: back-to-back with data_ready held
      gaps.delete();
      @(negedge clk);
      data_a = 8'h3C;
      dr_a   = 1'b1;
      repeat (3) exp_q.push_back('{data: 8'h3C, sb: 1});
      rises = 0;
      prev  = busy_a;
      for (int i = 0; i < 1000 && rises < 3; i++) begin
         @(negedge clk);
         if (busy_a === 1'b1 && prev === 1'b0) rises++;
         prev = busy_a;
      end
      dr_a = 1'b0;
      chk("b2b_rises", rises, 3);
      wait_sb(800);
      chk("b2b_frames", gaps.size(), 3);
      if (gaps.size() == 3) begin
         chk("b2b_gap1", gaps[1], 1);
         chk("b2b_gap2", gaps[2], 1);
      end

      // 5: reset during data bit 3 of 0x00, then a clean 0x81
      mon_en = 1'b0;
      @(negedge clk);
      data_a = 8'h00;
      dr_a   = 1'b1;
      @(negedge clk);
      dr_a = 1'b0;
      repeat (69) @(negedge clk);
      chk("pre_reset_tx", int'(tx_a), 0);
      chk("pre_reset_busy", int'(busy_a), 1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("mid_reset_tx", int'(tx_a), 1);
      chk("mid_reset_busy", int'(busy_a), 0);
      chk("mid_reset_done", int'(done_a), 0);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
      end
      chk("post_reset_idle_bad_cycles", bad, 0);
      mon_en = 1'b1;
      pulse_a(8'h81);
      wait_sb(400);

      // 6: two stop bits on the second instance
      sel = 1'b1;
      @(negedge clk);
      data_b = 8'hFF;
      dr_b   = 1'b1;
      exp_q.push_back('{data: 8'hFF, sb: 2});
      @(negedge clk);
      dr_b = 1'b0;
      wait_sb(400);
      sel = 1'b0;

      // Upstream-style handshake stream
      repeat (5) @(negedge clk);
      send_hs(8'h01);
      send_hs(8'h02);
      send_hs(8'h03);
      wait_sb(800);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
